// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master core: SCL phase states and common sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

    localparam int DEF_PRESCALE_WIDTH = 8;
    localparam int SYNC_STAGES        = 2;

    // One SCL period is four quarter-phases; IDLE parks with SCL released.
    typedef enum logic [2:0] {
        IDLE,
        LOW_A,
        LOW_B,
        HIGH_A,
        HIGH_B
    } phase_t;

endpackage

// File: rtl/i2c_clock_generator_if.sv
// Control and pad bundle between the register block / bit FSM and the SCL generator.
// Ports: prescale_i/enable_i/scl_line_i into the generator; scl_o and phase strobes out.
// Backpressure: none; all signals are levels or single-cycle strobes.
interface i2c_clock_generator_if
    import i2c_pkg::*;
#(
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
);
    logic [PRESCALE_WIDTH-1:0] prescale_i;
    logic                      enable_i;
    logic                      scl_line_i;
    logic                      scl_o;
    logic                      scl_fall_o;
    logic                      data_change_o;
    logic                      scl_rise_o;
    logic                      sample_o;
    logic                      busy_o;

    modport master (
        output prescale_i, enable_i, scl_line_i,
        input  scl_o, scl_fall_o, data_change_o, scl_rise_o, sample_o, busy_o
    );

    modport slave (
        input  prescale_i, enable_i, scl_line_i,
        output scl_o, scl_fall_o, data_change_o, scl_rise_o, sample_o, busy_o
    );
endinterface

// File: rtl/sync_2ff.sv
// Single-bit metastability synchronizer for asynchronous pad inputs (SCL, later SDA).
// Latency: SYNC_STAGES clock cycles from d to q.
// Backpressure: none.
module sync_2ff
    import i2c_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SYNC_STAGES-1];
endmodule

// File: rtl/i2c_clock_generator.sv
// SCL timebase: four quarter-phases of Q=P+1 cycles with fall/data-change/rise/sample strobes.
// Latency: scl_o and strobes registered; first SCL fall one cycle after enable is seen in IDLE.
// Backpressure: a slave holding SCL low stretches the high phase until the line reads high.
module i2c_clock_generator
    import i2c_pkg::*;
#(
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                    pclk_i,
    input  logic                    preset_ni,
    i2c_clock_generator_if.slave    bus
);
    phase_t                    state;
    logic [PRESCALE_WIDTH-1:0] cnt;
    logic [PRESCALE_WIDTH-1:0] p_q;
    logic                      scl_line_s;
    logic                      scl_r;
    logic                      fall_r;
    logic                      dchg_r;
    logic                      rise_r;
    logic                      samp_r;
    logic                      busy_r;

    sync_2ff #(.RST_VAL(1'b1)) u_scl_sync (
        .clk   (pclk_i),
        .rst_n (preset_ni),
        .d     (bus.scl_line_i),
        .q     (scl_line_s)
    );

    wire last = (cnt == p_q);

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state  <= IDLE;
            cnt    <= '0;
            p_q    <= '0;
            scl_r  <= 1'b1;
            fall_r <= 1'b0;
            dchg_r <= 1'b0;
            rise_r <= 1'b0;
            samp_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            fall_r <= 1'b0;
            dchg_r <= 1'b0;
            rise_r <= 1'b0;
            samp_r <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.enable_i) begin
                        state  <= LOW_A;
                        p_q    <= bus.prescale_i;
                        scl_r  <= 1'b0;
                        fall_r <= 1'b1;
                        busy_r <= 1'b1;
                    end
                end
                LOW_A: begin
                    if (last) begin
                        state  <= LOW_B;
                        cnt    <= '0;
                        dchg_r <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOW_B: begin
                    if (last) begin
                        state  <= HIGH_A;
                        cnt    <= '0;
                        scl_r  <= 1'b1;
                        rise_r <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH_A: begin
                    // Counter parks at P_q until the synchronized line confirms
                    // SCL really went high (covers slave stretching and the
                    // synchronizer delay for tiny prescales).
                    if (last) begin
                        if (scl_line_s) begin
                            state  <= HIGH_B;
                            cnt    <= '0;
                            samp_r <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH_B: begin
                    if (last) begin
                        cnt <= '0;
                        if (bus.enable_i) begin
                            state  <= LOW_A;
                            p_q    <= bus.prescale_i;
                            scl_r  <= 1'b0;
                            fall_r <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    scl_r  <= 1'b1;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.scl_o         = scl_r;
    assign bus.scl_fall_o    = fall_r;
    assign bus.data_change_o = dchg_r;
    assign bus.scl_rise_o    = rise_r;
    assign bus.sample_o      = samp_r;
    assign bus.busy_o        = busy_r;
endmodule

// File: tb/tb_i2c_clock_generator.sv
// Bench for i2c_clock_generator: period table, corner sequences, randomized run
// against an event-time reference model of the SCL period.
// The SCL pad is modelled as a wired-AND of the DUT drive and a slave pull-down.
module tb_i2c_clock_generator;
    import i2c_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic hold_low = 1'b0;
    always #5 clk = ~clk;

    i2c_clock_generator_if bus ();
    assign bus.scl_line_i = bus.scl_o & ~hold_low;

    i2c_clock_generator dut (
        .pclk_i    (clk),
        .preset_ni (rst_n),
        .bus       (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: times (in cycles) of the current period's events.
    int   cyc;
    bit   m_act;
    int   t_fall, m_p, m_q, t_samp;
    bit   pad_h [3];
    logic [5:0] exp_o;
    int   hold_cnt;
    bit   rnd_hold;
    bit   arm;
    int   arm_len;

    typedef struct {
        int p;
        int stretch;
        int dc;
        int rise;
        int samp;
        int per;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic model_reset();
        m_act    = 1'b0;
        t_samp   = -1;
        pad_h    = '{1'b1, 1'b1, 1'b1};
        hold_cnt = 0;
        arm      = 1'b0;
        cyc      = 0;
    endtask

    task automatic model_start(input int n);
        m_act  = 1'b1;
        t_fall = n;
        m_p    = int'(bus.prescale_i);
        m_q    = m_p + 1;
        t_samp = -1;
    endtask

    // Outputs {scl, fall, data_change, rise, sample, busy} expected in cycle n.
    function automatic logic [5:0] model_out(input int n);
        int tr;
        if (!m_act) return 6'b100000;
        tr = t_fall + 2 * m_q;
        return {!(n >= t_fall && n < tr), n == t_fall, n == t_fall + m_q,
                n == tr, n == t_samp, 1'b1};
    endfunction

    function automatic int dut_out();
        return int'({bus.scl_o, bus.scl_fall_o, bus.data_change_o,
                     bus.scl_rise_o, bus.sample_o, bus.busy_o});
    endfunction

    task automatic tick();
        int nxt;
        @(posedge clk);
        nxt = cyc + 1;
        if (!m_act) begin
            if (bus.enable_i) model_start(nxt);
        end else if (t_samp < 0) begin
            // Sample follows the first cycle at/after the high quarter's end
            // in which the synchronized line (pad two cycles earlier) is high.
            if (nxt - 1 >= t_fall + 2 * m_q + m_p && pad_h[2]) t_samp = nxt;
        end else if (nxt == t_samp + m_q) begin
            if (bus.enable_i) model_start(nxt);
            else m_act = 1'b0;
        end
        cyc   = nxt;
        exp_o = model_out(cyc);
        @(negedge clk);
        check("outputs", dut_out(), int'(exp_o));
        if (arm && exp_o[2]) begin
            hold_cnt = arm_len;
            arm      = 1'b0;
        end
        hold_low = (hold_cnt > 0) || rnd_hold;
        if (hold_cnt > 0) hold_cnt--;
        pad_h[2] = pad_h[1];
        pad_h[1] = pad_h[0];
        pad_h[0] = exp_o[5] & ~hold_low;
    endtask

    task automatic wait_fall(output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.scl_fall_o) begin
                at = cyc;
                return;
            end
        end
        check("fall_timeout", 0, 1);
    endtask

    task automatic measure_period(output int per);
        int t0;
        per = -1;
        wait_fall(t0);
        for (int k = 0; k < 300; k++) begin
            tick();
            if (bus.scl_fall_o) begin
                per = cyc - t0;
                return;
            end
        end
    endtask

    initial begin
        int t0, fdc, fri, fsa, per, n_fall, n_rise, n_samp;

        tbl[0] = '{4, 0, 5, 10, 15, 20};
        tbl[1] = '{4, 0, 5, 10, 15, 20};
        tbl[2] = '{4, 0, 5, 10, 15, 20};
        tbl[3] = '{9, 0, 10, 20, 30, 40};
        tbl[4] = '{0, 0, 1, 2, 5, 6};
        tbl[5] = '{1, 0, 2, 4, 7, 9};
        tbl[6] = '{2, 0, 3, 6, 9, 12};
        tbl[7] = '{4, 12, 5, 10, 25, 30};

        rnd_hold       = 1'b0;
        bus.enable_i   = 1'b1;
        bus.prescale_i = 8'd4;
        model_reset();

        // Reset held with enable high: SCL released, no activity.
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", dut_out(), 6'b100000);
        end
        rst_n = 1'b1;
        model_reset();
        tick();
        check("fall_after_reset", int'(bus.scl_fall_o), 1);

        // Period table; next entry's prescale is applied during HIGH_A so
        // consecutive entries are back-to-back periods.
        t0 = -1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                bus.prescale_i = 8'(tbl[0].p);
                wait_fall(t0);
            end
            fdc = -1; fri = -1; fsa = -1; per = -1;
            arm_len = tbl[i].stretch;
            arm     = (tbl[i].stretch > 0);
            for (int k = 0; k < 300; k++) begin
                tick();
                if (bus.data_change_o && fdc < 0) fdc = cyc - t0;
                if (bus.scl_rise_o && fri < 0) begin
                    fri = cyc - t0;
                    if (i + 1 < 8) bus.prescale_i = 8'(tbl[i+1].p);
                end
                if (bus.sample_o && fsa < 0) fsa = cyc - t0;
                if (bus.scl_fall_o) begin
                    per = cyc - t0;
                    break;
                end
            end
            check($sformatf("vec%0d_data_change", i), fdc, tbl[i].dc);
            check($sformatf("vec%0d_rise", i), fri, tbl[i].rise);
            check($sformatf("vec%0d_sample", i), fsa, tbl[i].samp);
            check($sformatf("vec%0d_period", i), per, tbl[i].per);
            t0 = cyc;
        end

        // Enable dropped during LOW_B: period completes, then idle.
        bus.prescale_i = 8'd4;
        wait_fall(t0);
        repeat (7) tick();
        bus.enable_i = 1'b0;
        n_fall = 0; n_rise = 0; n_samp = 0;
        repeat (40) begin
            tick();
            n_fall += int'(bus.scl_fall_o);
            n_rise += int'(bus.scl_rise_o);
            n_samp += int'(bus.sample_o);
        end
        check("drop_falls", n_fall, 0);
        check("drop_rises", n_rise, 1);
        check("drop_samples", n_samp, 1);
        check("drop_busy", int'(bus.busy_o), 0);
        check("drop_scl", int'(bus.scl_o), 1);

        // Randomized run: enable toggles, prescale churn, random slave pulls.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) bus.enable_i = ~bus.enable_i;
            if ($urandom_range(0, 3) == 0) bus.prescale_i = 8'($urandom_range(0, 5));
            rnd_hold = ($urandom_range(0, 9) == 0);
            tick();
        end
        rnd_hold = 1'b0;

        // Asynchronous reset in HIGH_A with P=0, checked between clock edges.
        bus.prescale_i = 8'd0;
        bus.enable_i   = 1'b1;
        fri = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (bus.scl_rise_o) begin
                fri = 1;
                break;
            end
        end
        check("p0_rise_seen", fri, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", dut_out(), 6'b100000);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        measure_period(per);
        check("p0_period", per, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
